// File: rtl/binom_pkg.sv
`default_nettype none
// ============================================================================
// binom_pkg : shared types and constants for the binomial sampler stream
// Revision  : 1.0
// ============================================================================
package binom_pkg;

  localparam int KMAX      = 8;
  localparam int Q_NEWHOPE = 12289;
  localparam int Q_KYBER   = 3329;

  typedef enum logic [1:0] {
    K2 = 2'b00,
    K3 = 2'b01,
    K4 = 2'b10,
    K8 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [3:0] k_of_mode(input mode_e m);
    logic [3:0] k;
    case (m)
      K2:      k = 4'd2;
      K3:      k = 4'd3;
      K4:      k = 4'd4;
      default: k = 4'd8;
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/binom_lane.sv
`default_nettype none
// ============================================================================
// binom_lane : one centered-binomial coefficient from a/b bit slices (comb.)
// Revision   : 1.0
// ============================================================================
module binom_lane
  import binom_pkg::*;
#(
  parameter int COEFF_WIDTH = 16,
  parameter int PARAM_Q     = 12289
) (
  input  logic [KMAX-1:0]        a_i,
  input  logic [KMAX-1:0]        b_i,
  input  logic [3:0]             k_i,
  output logic [COEFF_WIDTH-1:0] coeff_o
);

  logic [3:0]        w_pa;
  logic [3:0]        w_pb;
  logic signed [4:0] w_d;
  logic [4:0]        w_mag;

  // Only the low k bits of each slice belong to this lane.
  always_comb begin
    w_pa = '0;
    w_pb = '0;
    for (int i = 0; i < KMAX; i++) begin
      if (4'(i) < k_i) begin
        w_pa = w_pa + 4'(a_i[i]);
        w_pb = w_pb + 4'(b_i[i]);
      end
    end
  end

  assign w_d   = $signed({1'b0, w_pa}) - $signed({1'b0, w_pb});
  assign w_mag = 5'(-w_d);

`ifdef BINOM_STREAM_SIGNED_EN
  assign coeff_o = {{(COEFF_WIDTH-5){w_d[4]}}, w_d};
`else
  assign coeff_o = w_d[4] ? (COEFF_WIDTH'(PARAM_Q) - COEFF_WIDTH'(w_mag))
                          : COEFF_WIDTH'(w_d[3:0]);
`endif

endmodule
`default_nettype wire

// File: rtl/binom_sample_stream.sv
`default_nettype none
// ============================================================================
// binom_sample_stream : streaming centered binomial sampler, LANES coeffs/beat
// Build option        : BINOM_STREAM_SIGNED_EN -> two's-complement lane output
// Revision            : 1.0
// ============================================================================
module binom_sample_stream
  import binom_pkg::*;
#(
  parameter int IN_WIDTH    = 32,
  parameter int LANES       = 2,
  parameter int COEFF_WIDTH = 16,
  parameter int PARAM_Q     = 12289,
  parameter int N           = 256,
  parameter int BUF_WIDTH   = 2*IN_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [1:0]                   mode_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [IN_WIDTH-1:0]          in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [LANES*COEFF_WIDTH-1:0] out_data_o,
  output logic                         out_last_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int FILL_W = $clog2(BUF_WIDTH+1);
  localparam int BEATS  = N/LANES;
  localparam int BEAT_W = $clog2(BEATS+1);

  if (2*KMAX*LANES > IN_WIDTH) begin : g_chk_lanes
    $error("binom_sample_stream: 2*8*LANES must not exceed IN_WIDTH");
  end
  if (longint'(PARAM_Q) >= (64'd1 << COEFF_WIDTH)) begin : g_chk_q
    $error("binom_sample_stream: PARAM_Q must fit in COEFF_WIDTH");
  end
  if ((N % LANES) != 0) begin : g_chk_n
    $error("binom_sample_stream: N must be a multiple of LANES");
  end

  state_e                       state_q, state_d;
  mode_e                        mode_q, mode_d;
  logic [FILL_W-1:0]            fill_q, fill_d;
  logic [BUF_WIDTH-1:0]         buf_q, buf_d;
  logic [BEAT_W-1:0]            beats_q, beats_d;
  logic                         ov_q, ov_d;
  logic                         last_q, last_d;
  logic [LANES*COEFF_WIDTH-1:0] data_q, data_d;

  logic [3:0]                   w_k;
  logic [FILL_W-1:0]            w_need;
  logic [FILL_W-1:0]            w_base;
  logic                         w_in_ready;
  logic                         w_accept;
  logic                         w_load;
  logic                         w_out_hs;
  logic [LANES*COEFF_WIDTH-1:0] w_lanes;

  assign w_k    = k_of_mode(mode_q);
  assign w_need = FILL_W'({w_k, 1'b0}) * FILL_W'(LANES);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [FILL_W-1:0] w_off;
    assign w_off = FILL_W'({w_k, 1'b0}) * FILL_W'(j);

    binom_lane #(
      .COEFF_WIDTH (COEFF_WIDTH),
      .PARAM_Q     (PARAM_Q)
    ) u_lane (
      .a_i     (KMAX'(buf_q >> w_off)),
      .b_i     (KMAX'(buf_q >> (w_off + FILL_W'(w_k)))),
      .k_i     (w_k),
      .coeff_o (w_lanes[j*COEFF_WIDTH +: COEFF_WIDTH])
    );
  end

  assign w_in_ready = (state_q == RUN) && (fill_q <= FILL_W'(BUF_WIDTH-IN_WIDTH));
  assign w_accept   = in_valid_i && w_in_ready;
  assign w_out_hs   = ov_q && out_ready_i;
  assign w_load     = (state_q == RUN) && (fill_q >= w_need) && (beats_q != '0) &&
                      (!ov_q || out_ready_i);
  // A word arriving in the same cycle as a load lands just above the bits that remain.
  assign w_base     = w_load ? (fill_q - w_need) : fill_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    beats_d = beats_q;
    ov_d    = ov_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          mode_d  = mode_e'(mode_i);
          fill_d  = '0;
          buf_d   = '0;
          beats_d = BEAT_W'(BEATS);
        end
      end
      RUN: begin
        buf_d  = (w_load ? (buf_q >> w_need) : buf_q) |
                 (w_accept ? (BUF_WIDTH'(in_data_i) << w_base) : '0);
        fill_d = w_base + (w_accept ? FILL_W'(IN_WIDTH) : '0);
        if (w_load) begin
          ov_d    = 1'b1;
          data_d  = w_lanes;
          last_d  = (beats_q == BEAT_W'(1));
          beats_d = beats_q - BEAT_W'(1);
        end else if (w_out_hs) begin
          ov_d   = 1'b0;
          last_d = 1'b0;
        end
        if (w_out_hs && last_q) begin
          state_d = DONE;
          fill_d  = '0;
          buf_d   = '0;
          ov_d    = 1'b0;
          last_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= K2;
      fill_q  <= '0;
      buf_q   <= '0;
      beats_q <= '0;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      beats_q <= beats_d;
      ov_q    <= ov_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = ov_q;
  assign out_last_o  = ov_q && last_q;
  assign out_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_binom_sample_stream.sv
`default_nettype none
// ============================================================================
// tb_binom_sample_stream : vectors plus bit-queue reference model bench
// Revision               : 1.0
// ============================================================================
module tb_binom_sample_stream;

  localparam int IW    = 32;
  localparam int L     = 2;
  localparam int CW    = 16;
  localparam int Q     = 12289;
  localparam int NN    = 256;
  localparam int BEATS = NN/L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready_o, out_valid_o, out_last_o, busy_o, done_o;
  logic [L*CW-1:0] out_data_o;

  binom_sample_stream #(
    .IN_WIDTH(IW), .LANES(L), .COEFF_WIDTH(CW), .PARAM_Q(Q), .N(NN), .BUF_WIDTH(2*IW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_data_i(in_data),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kval(input logic [1:0] m);
    case (m)
      2'b00:   return 2;
      2'b01:   return 3;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [CW-1:0] exp_coeff(input int d);
`ifdef BINOM_STREAM_SIGNED_EN
    return CW'(d);
`else
    return (d < 0) ? CW'(d + Q) : CW'(d);
`endif
  endfunction

  // Reference model: a plain queue of accepted bits, consumed LSB first.
  bit  bitq[$];
  int  m_k = 2;
  int  m_beats = 0;
  int  m_lasts = 0;
  int  m_words = 0;
  int  m_rdy_low = 0;
  int  done_pending = 0;
  bit  seen_done = 0;

  always @(negedge clk) begin : mon
    logic [L*CW-1:0] ev;
    int pa, pb;
    if (rst) begin
      bitq.delete();
      m_beats = 0;
      done_pending = 0;
    end else begin
      if (done_o) seen_done = 1;
      if (done_pending == 1) begin
        chk("done_pulse", done_o, 1'b1);
        chk("busy_in_done", busy_o, 1'b1);
        done_pending = 2;
      end else if (done_pending == 2) begin
        chk("done_single", done_o, 1'b0);
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_in_ready", in_ready_o, 1'b0);
        done_pending = 0;
      end
      if (busy_o && !done_o && !in_ready_o) m_rdy_low++;
      if (start && !busy_o) begin
        bitq.delete();
        m_k = kval(mode);
        m_beats = 0;
        m_lasts = 0;
        m_words = 0;
        m_rdy_low = 0;
      end
      if (in_valid && in_ready_o) begin
        m_words++;
        for (int i = 0; i < IW; i++) bitq.push_back(in_data[i]);
      end
      if (out_valid_o && out_ready) begin
        m_beats++;
        if (out_last_o) m_lasts++;
        if (bitq.size() < 2*m_k*L) begin
          chk("model_underflow", 64'(bitq.size()), 64'(2*m_k*L));
        end else begin
          ev = '0;
          for (int j = 0; j < L; j++) begin
            pa = 0;
            pb = 0;
            for (int i = 0; i < m_k; i++) pa += int'(bitq.pop_front());
            for (int i = 0; i < m_k; i++) pb += int'(bitq.pop_front());
            ev[j*CW +: CW] = exp_coeff(pa - pb);
          end
          chk("beat_data", out_data_o, ev);
        end
        chk("beat_last", out_last_o, (m_beats == BEATS));
        if (out_last_o) done_pending = 1;
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] word;
    int          d0;
    int          d1;
  } vec_t;
  vec_t vt[7];

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    start = 0; in_valid = 0; out_ready = 0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_poly(input logic [1:0] m, input int pat, input int vpct,
                          input bit bp, input int abort_at);
    bit held = 0;
    bit poked = 0;
    bit aborted = 0;
    logic [L*CW-1:0] hd;
    logic hl;
    seen_done = 0;
    @(posedge clk); #1 start = 1'b1; mode = m; out_ready = 0; in_valid = 0;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_rise", busy_o, 1'b1);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (seen_done && !busy_o) break;
      if (abort_at > 0 && m_beats >= abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready_o, 1'b0);
        chk("abort_out_valid", out_valid_o, 1'b0);
        chk("abort_out_last", out_last_o, 1'b0);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        chk("abort_out_data", out_data_o, '0);
        in_valid = 0; out_ready = 0; start = 0;
        @(posedge clk); #1 rst = 1'b0;
        aborted = 1;
        break;
      end
      in_valid  = ($urandom_range(99) < vpct);
      in_data   = (pat == 1) ? '1 : IW'($urandom);
      out_ready = bp ? ($urandom_range(3) != 0) : 1'b1;
      if (bp && !held && m_beats >= 20 && out_valid_o) begin
        held = 1;
        hd = out_data_o;
        hl = out_last_o;
        out_ready = 0;
        in_valid = 1;
        repeat (5) begin
          @(posedge clk); #1;
          chk("bp_data_hold", out_data_o, hd);
          chk("bp_last_hold", out_last_o, hl);
        end
        chk("bp_in_ready_low", in_ready_o, 1'b0);
        out_ready = 1;
      end
      if (bp && !poked && m_beats >= 10) begin
        start = 1'b1;
        mode = 2'b11;
        poked = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 0; in_valid = 0; out_ready = 0;
    if (!aborted && !(seen_done && !busy_o)) begin
      chk("poly_timeout", 64'(m_beats), 64'(BEATS));
      pulse_reset();
    end
  endtask

  initial begin
    vt[0] = '{2'b00, 32'h0000_007A,  0,  1};
    vt[1] = '{2'b00, 32'h0000_000C, -2,  0};
    vt[2] = '{2'b11, 32'h0000_00FF,  8,  0};
    vt[3] = '{2'b11, 32'hFF00_0000,  0, -8};
    vt[4] = '{2'b01, 32'h0000_0007,  3,  0};
    vt[5] = '{2'b10, 32'h0000_F000,  0, -4};
    vt[6] = '{2'b10, 32'h0000_00F1, -3,  0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_last", out_last_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_out_data", out_data_o, '0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      pulse_reset();
      @(posedge clk); #1 start = 1'b1; mode = vt[v].mode;
      @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; in_data = vt[v].word;
      @(posedge clk); #1 in_valid = 1'b0;
      chk("vec_latency_early", out_valid_o, 1'b0);
      @(posedge clk); #1;
      chk("vec_valid", out_valid_o, 1'b1);
      chk("vec_lane0", out_data_o[0 +: CW], exp_coeff(vt[v].d0));
      chk("vec_lane1", out_data_o[CW +: CW], exp_coeff(vt[v].d1));
    end
    pulse_reset();

    run_poly(2'b11, 0, 100, 1'b0, 0);
    chk("k8_beats", 64'(m_beats), 64'(BEATS));
    chk("k8_ready_high", 64'(m_rdy_low), 64'd0);

    run_poly(2'b01, 1, 100, 1'b0, 0);
    chk("k3_beats", 64'(m_beats), 64'(BEATS));
    chk("k3_leftover_range",
        ((m_words*IW - 12*BEATS) >= 0) && ((m_words*IW - 12*BEATS) <= 2*IW), 1'b1);

    run_poly(2'b00, 0, 70, 1'b1, 0);
    chk("k2_bp_beats", 64'(m_beats), 64'(BEATS));
    chk("k2_bp_lasts", 64'(m_lasts), 64'd1);

    run_poly(2'b10, 0, 60, 1'b0, 0);
    chk("k4_beats", 64'(m_beats), 64'(BEATS));

    run_poly(2'b00, 0, 100, 1'b0, 40);
    run_poly(2'b10, 0, 80, 1'b0, 0);
    chk("post_abort_beats", 64'(m_beats), 64'(BEATS));
    chk("post_abort_lasts", 64'(m_lasts), 64'd1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/binom_sample_stream.md
# binom_sample_stream

Streaming, parametrised centered binomial sampler for the PQ accelerator datapath. It consumes a stream of uniform random words (SHAKE/PRNG output) through a valid/ready handshake and buffers them in a bit accumulator. It emits LANES coefficients per beat, each (popcount(a) − popcount(b)) reduced mod PARAM_Q, for k ∈ {2,3,4,8}. It counts a full polynomial of N coefficients per start, and supersedes the single-shot combinational sampler.

## Interface
- IN_WIDTH, 32: random input word width.
- LANES, 2: coefficients per output beat.
- COEFF_WIDTH, 16: output coefficient width.
- PARAM_Q, 12289: modulus. 3329 is also supported.
- N, 256: coefficients per polynomial. Must be a multiple of LANES.
- BUF_WIDTH, 2*IN_WIDTH: bit-accumulator width.
- Elaboration assertions: 2*8*LANES ≤ IN_WIDTH; PARAM_Q < 2^COEFF_WIDTH.

One clock; reset is asynchronous and active-high.

- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a polynomial. Honoured only in IDLE.
- mode_i  in  2  00 k=2, 01 k=3, 10 k=4, 11 k=8. Latched on accepted start.
- in_valid_i  in  1  random word valid.
- in_ready_o  out  1  accumulator can take a word.
- in_data_i  in  IN_WIDTH  random bits, consumed LSB first.
- out_valid_o  out  1  coefficient beat valid.
- out_ready_i  in  1  downstream accepts beat.
- out_data_o  out  LANES*COEFF_WIDTH  lane j in bits [j*COEFF_WIDTH +: COEFF_WIDTH].
- out_last_o  out  1  qualifies the final beat of the polynomial.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle pulse after the last beat handshake.

## Operation
- States:
  - IDLE → RUN on start_i. This clears fill and sets the beat counter to N/LANES.
  - RUN → DONE on the out handshake that has out_last_o=1.
  - DONE → IDLE unconditionally. done_o=1 in DONE.
- Accumulator: fill counter 0..BUF_WIDTH. in_ready_o = (state==RUN) && fill ≤ BUF_WIDTH−IN_WIDTH, computed from the registered fill.
- Consumption: need = 2*k*LANES bits per beat. Lane j uses a = bits [2kj +: k] and b = bits [2kj+k +: k] of the buffer LSBs.
- Output register loads when state==RUN && fill ≥ need && beats_left>0 && (!out_valid_o || out_ready_i). On load, the buffer shifts right by need and beats_left decrements.
- Simultaneous input accept and load: new fill = fill + IN_WIDTH − need. The new word lands at bit position (fill − need).
- Arithmetic: d = popcount(a) − popcount(b), range −k..k. Output is d when d ≥ 0, otherwise d + PARAM_Q. The result is zero-extended to COEFF_WIDTH.
- out_last_o = out_valid_o && (beat held is the (N/LANES)-th).
- On entering DONE, leftover buffer bits are discarded (fill cleared). start_i in RUN/DONE is ignored, and mode_i changes mid-run have no effect.
- Backpressure: while out_valid_o && !out_ready_i, out_data_o and out_last_o hold stable. Input continues to be accepted until the buffer is full.

## Timing
- Reset values: state IDLE, fill 0, beats_left 0. Outputs in_ready_o, out_valid_o, out_last_o, busy_o, done_o are 0, and out_data_o is 0.
- Reset asserted mid-run aborts immediately to these values. No partial beat survives.
- busy_o rises the cycle after start_i is sampled.
- Latency: a word accepted at edge E that satisfies need yields out_valid_o=1 after edge E+1.
- Throughput: one beat per cycle while fill ≥ need.
  - With IN_WIDTH=32 and LANES=2: k=8 gives 1 beat per word; k=2 gives 4 beats per word.
- done_o pulses in the cycle after the last out handshake. busy_o falls one cycle after that.

## Configuration
- BINOM_STREAM_SIGNED_EN defined: each lane outputs d as two's complement, sign-extended to COEFF_WIDTH, and PARAM_Q is unused.
- BINOM_STREAM_SIGNED_EN undefined: each lane outputs the mod-Q value as specified above.

## Structure
- Package binom_pkg holds:
  - the mode enum (K2, K3, K4, K8);
  - a k-from-mode function;
  - the state enum (IDLE, RUN, DONE);
  - constants KMAX=8, Q_NEWHOPE=12289, Q_KYBER=3329.
- Sub-module binom_lane is combinational: a/b slices and k in, one reduced coefficient out. It is instantiated LANES times.

## Test plan
- k=2, word 0x0000007A → lane0=0, lane1=1. With word 0x0000000C → lane0=12287, lane1=0. With BINOM_STREAM_SIGNED_EN, lane0 is instead 0xFFFE.
- k=8, word 0x000000FF → lane0=8, lane1=0. Exactly one beat per word; in_ready_o stays high at fill 0.
- k=3, continuous 0xFFFFFFFF → all lanes 0. Check fill wrap across word boundaries (12 bits per beat) and beat count vs accepted words.
- Backpressure: hold out_ready_i low for 5 cycles mid-run → out_data_o stable. in_ready_o drops once fill > 32. No bits are lost after release, checked by a reference-model compare.
- N=256, k=2: 128 beats. out_last_o is set only on beat 128. done_o is a single pulse, then IDLE with in_ready_o=0. start_i during RUN is ignored.
- Assert rst_i at beat 40 → all outputs 0 immediately. A new start produces a correct first beat from fresh input.
